// File: rtl/enet_core_bridge.sv
// ============================================================================
// Module      : enet_core_bridge
// Description : Ethernet-side 64-bit word bridge. TX buffers controller words
//               into packets for the MAC; RX buffers MAC words for the
//               controller. Optional macro ENET_TX_FLUSH_EN sends a partial
//               TX packet when i_enet_enable falls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enet_core_bridge #(
    parameter int PKT_WORDS     = 128,
    parameter int TX_FIFO_DEPTH = 256,
    parameter int RX_FIFO_DEPTH = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enet_enable,
    input  logic        i_core_data_avail,
    output logic        o_enet_ready,
    input  logic [63:0] i_data,
    output logic        o_enet_data_avail,
    input  logic        i_core_ready,
    output logic [63:0] o_data,
    output logic        o_tx_mac_count,
    output logic [63:0] o_tx_tdata,
    output logic        o_tx_tvalid,
    output logic        o_tx_tlast,
    input  logic        i_tx_tready,
    input  logic [63:0] i_rx_tdata,
    input  logic        i_rx_tvalid,
    output logic        o_rx_overflow
);

    localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
    localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
    localparam int CW    = $clog2(PKT_WORDS) + 1;
    localparam int PW    = TX_AW + 1;

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_DONE = 2'd2} tx_state_t;

    // ---------------- TX buffer ----------------
    logic [63:0]    tx_mem_q [TX_FIFO_DEPTH];
    logic [TX_AW:0] tx_wr_ptr_q, tx_rd_ptr_q, tx_count;
    logic           tx_full, tx_wr, tx_pop, enet_ready;
    logic [CW-1:0]  wr_word_cnt_q, wr_word_cnt_d, cur_len;
    logic [PW-1:0]  pkts_ready_q, pkts_ready_d;
    logic           pkt_done, flush, pkt_add, pkt_sub;

    tx_state_t      tx_state_q;
    logic           tvalid_q, tlast_q, mac_count_q;
    logic [CW-1:0]  beat_q;

    assign tx_count = tx_wr_ptr_q - tx_rd_ptr_q;
    assign tx_full  = (tx_count == (TX_AW+1)'(TX_FIFO_DEPTH));
    assign tx_wr    = i_core_data_avail & enet_ready;
    assign tx_pop   = tvalid_q & i_tx_tready;
    assign pkt_done = tx_wr & (wr_word_cnt_q == CW'(PKT_WORDS - 1));
    assign pkt_add  = pkt_done | flush;
    assign pkt_sub  = (tx_state_q == TX_DONE);

`ifdef ENET_TX_FLUSH_EN
    logic          enable_q;
    logic [CW-1:0] len_mem_q [4];
    logic [1:0]    len_wr_q, len_rd_q;

    // Writes are held off at three queued packets so a flush never overruns the length queue.
    assign flush      = enable_q & ~i_enet_enable & (wr_word_cnt_q != '0);
    assign cur_len    = len_mem_q[len_rd_q];
    assign enet_ready = i_enet_enable & ~tx_full & (pkts_ready_q < PW'(3));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            enable_q <= 1'b0;
            len_wr_q <= '0;
            len_rd_q <= '0;
        end else begin
            enable_q <= i_enet_enable;
            if (pkt_add) begin
                len_mem_q[len_wr_q] <= pkt_done ? CW'(PKT_WORDS) : wr_word_cnt_q;
                len_wr_q            <= len_wr_q + 2'd1;
            end
            if (pkt_sub)
                len_rd_q <= len_rd_q + 2'd1;
        end
    end
`else
    assign flush      = 1'b0;
    assign cur_len    = CW'(PKT_WORDS);
    assign enet_ready = i_enet_enable & ~tx_full;
`endif

    always_comb begin
        wr_word_cnt_d = wr_word_cnt_q;
        if (pkt_add)
            wr_word_cnt_d = '0;
        else if (tx_wr)
            wr_word_cnt_d = wr_word_cnt_q + CW'(1);
        pkts_ready_d = pkts_ready_q + PW'(pkt_add) - PW'(pkt_sub);
    end

    always_ff @(posedge i_clk) begin
        if (tx_wr)
            tx_mem_q[tx_wr_ptr_q[TX_AW-1:0]] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            wr_word_cnt_q <= '0;
            pkts_ready_q  <= '0;
        end else begin
            if (tx_wr)
                tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
            if (tx_pop)
                tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
            wr_word_cnt_q <= wr_word_cnt_d;
            pkts_ready_q  <= pkts_ready_d;
        end
    end

    // tlast is precomputed one beat ahead so it stays a registered output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state_q  <= TX_IDLE;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            mac_count_q <= 1'b0;
            beat_q      <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    mac_count_q <= 1'b0;
                    if (pkts_ready_q != '0) begin
                        tx_state_q <= TX_SEND;
                        tvalid_q   <= 1'b1;
                        beat_q     <= '0;
                        tlast_q    <= (cur_len == CW'(1));
                    end
                end
                TX_SEND: begin
                    if (i_tx_tready) begin
                        if (tlast_q) begin
                            tx_state_q  <= TX_DONE;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            mac_count_q <= 1'b1;
                        end else begin
                            beat_q  <= beat_q + CW'(1);
                            tlast_q <= (beat_q + CW'(2) == cur_len);
                        end
                    end
                end
                TX_DONE: begin
                    mac_count_q <= 1'b0;
                    tx_state_q  <= TX_IDLE;
                end
                default: begin
                    tx_state_q  <= TX_IDLE;
                    tvalid_q    <= 1'b0;
                    tlast_q     <= 1'b0;
                    mac_count_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_enet_ready   = enet_ready;
    assign o_tx_tvalid    = tvalid_q;
    assign o_tx_tlast     = tlast_q;
    assign o_tx_mac_count = mac_count_q;
    assign o_tx_tdata     = tvalid_q ? tx_mem_q[tx_rd_ptr_q[TX_AW-1:0]] : 64'd0;

    // ---------------- RX buffer ----------------
    logic [63:0]    rx_mem_q [RX_FIFO_DEPTH];
    logic [RX_AW:0] rx_wr_ptr_q, rx_rd_ptr_q, rx_count;
    logic           rx_full, rx_empty, rx_push, rx_pop, overflow_q;

    assign rx_count = rx_wr_ptr_q - rx_rd_ptr_q;
    assign rx_full  = (rx_count == (RX_AW+1)'(RX_FIFO_DEPTH));
    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign rx_pop   = ~rx_empty & i_core_ready;
    assign rx_push  = i_rx_tvalid & i_enet_enable & (~rx_full | rx_pop);

    always_ff @(posedge i_clk) begin
        if (rx_push)
            rx_mem_q[rx_wr_ptr_q[RX_AW-1:0]] <= i_rx_tdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (rx_push)
                rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
            if (rx_pop)
                rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
            if (i_rx_tvalid & i_enet_enable & rx_full & ~rx_pop)
                overflow_q <= 1'b1;
        end
    end

    assign o_enet_data_avail = ~rx_empty;
    assign o_data            = rx_empty ? 64'd0 : rx_mem_q[rx_rd_ptr_q[RX_AW-1:0]];
    assign o_rx_overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_enet_core_bridge.sv
// Scoreboard bench for enet_core_bridge: stimulus pushes expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
`default_nettype none

module tb_enet_core_bridge;

    localparam int PKT = 128;

    logic        clk = 1'b0;
    logic        i_rst, i_enet_enable, i_core_data_avail, i_core_ready;
    logic        i_tx_tready, i_rx_tvalid;
    logic [63:0] i_data, i_rx_tdata;
    logic        o_enet_ready, o_enet_data_avail, o_tx_mac_count;
    logic        o_tx_tvalid, o_tx_tlast, o_rx_overflow;
    logic [63:0] o_data, o_tx_tdata;

    always #5 clk = ~clk;

    enet_core_bridge dut (
        .i_clk(clk), .i_rst(i_rst), .i_enet_enable(i_enet_enable),
        .i_core_data_avail(i_core_data_avail), .o_enet_ready(o_enet_ready), .i_data(i_data),
        .o_enet_data_avail(o_enet_data_avail), .i_core_ready(i_core_ready), .o_data(o_data),
        .o_tx_mac_count(o_tx_mac_count), .o_tx_tdata(o_tx_tdata), .o_tx_tvalid(o_tx_tvalid),
        .o_tx_tlast(o_tx_tlast), .i_tx_tready(i_tx_tready), .i_rx_tdata(i_rx_tdata),
        .i_rx_tvalid(i_rx_tvalid), .o_rx_overflow(o_rx_overflow)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] txq[$];
    logic [63:0] rxq[$];
    int          exp_len_q[$];
    int          pulse_cnt = 0;
    int          beat_cnt  = 0;
    int          epoch     = 0;
    int          tready_mode = 0;
    int          wcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // MAC ready pattern: 0 = stalled, 1 = always ready, 2 = toggling
    initial begin
        i_tx_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0:       i_tx_tready = 1'b0;
                1:       i_tx_tready = 1'b1;
                default: i_tx_tready = ~i_tx_tready;
            endcase
        end
    end

    // Monitor
    initial begin
        int bidx;
        int my_epoch;
        int len;
        bidx = 0;
        my_epoch = 0;
        forever begin
            @(negedge clk);
            if (my_epoch != epoch) begin
                my_epoch = epoch;
                bidx = 0;
            end
            if (o_tx_mac_count) pulse_cnt++;
            if (bidx > 0 && i_tx_tready) check("tx_no_gap", o_tx_tvalid, 1'b1);
            if (o_tx_tvalid && i_tx_tready) begin
                beat_cnt++;
                if (txq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_extra_beat: got data %0h expected no beat", o_tx_tdata);
                end else begin
                    check("tx_data", o_tx_tdata, txq.pop_front());
                end
                len = (exp_len_q.size() != 0) ? exp_len_q[0] : PKT;
                check("tx_tlast", o_tx_tlast, (bidx == len - 1));
                if (bidx == len - 1) begin
                    bidx = 0;
                    if (exp_len_q.size() != 0) void'(exp_len_q.pop_front());
                end else begin
                    bidx++;
                end
            end
            if (o_enet_data_avail && i_core_ready) begin
                if (rxq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx_extra_word: got data %0h expected none", o_data);
                end else begin
                    check("rx_data", o_data, rxq.pop_front());
                end
            end
        end
    end

    task automatic write_words(input int n, input logic [63:0] start, input int budget, output int written);
        int  i, cyc;
        logic fire;
        i = 0; cyc = 0;
        i_core_data_avail = 1'b1;
        i_data = start;
        while (i < n && cyc < budget) begin
            @(negedge clk);
            fire = o_enet_ready;
            if (fire) begin
                txq.push_back(i_data);
                wcnt++;
                if (wcnt == PKT) begin
                    exp_len_q.push_back(PKT);
                    wcnt = 0;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                i++;
                i_data = start + 64'(i);
            end
        end
        i_core_data_avail = 1'b0;
        written = i;
    endtask

    task automatic wait_pulses(input int base, input int n, input int budget, input string name);
        int c;
        c = 0;
        while (pulse_cnt - base < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check(name, 64'(pulse_cnt - base), 64'(n));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        txq.delete(); rxq.delete(); exp_len_q.delete();
        wcnt = 0;
        epoch++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr, pb, bb, c;
        i_rst = 1'b1; i_enet_enable = 1'b0; i_core_data_avail = 1'b0; i_data = '0;
        i_core_ready = 1'b0; i_rx_tvalid = 1'b0; i_rx_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enet_ready", o_enet_ready, 1'b0);
        check("rst_tvalid", o_tx_tvalid, 1'b0);
        check("rst_tlast", o_tx_tlast, 1'b0);
        check("rst_mac_count", o_tx_mac_count, 1'b0);
        check("rst_data_avail", o_enet_data_avail, 1'b0);
        check("rst_overflow", o_rx_overflow, 1'b0);
        check("rst_tx_tdata", o_tx_tdata, 64'd0);
        check("rst_o_data", o_data, 64'd0);
        i_rst = 1'b0;
        epoch++;

        // 1: single packet, MAC always ready
        i_enet_enable = 1'b1; tready_mode = 1;
        pb = pulse_cnt; bb = beat_cnt;
        write_words(128, 64'd0, 200, wr);
        check("t1_written", 64'(wr), 64'd128);
        wait_pulses(pb, 1, 400, "t1_pulses");
        repeat (10) @(posedge clk);
        #1;
        check("t1_beats", 64'(beat_cnt - bb), 64'd128);
        check("t1_pulses_final", 64'(pulse_cnt - pb), 64'd1);
        check("t1_txq_empty", 64'(txq.size()), 64'd0);

        // 2: two packets, MAC ready toggling
        tready_mode = 2;
        pb = pulse_cnt; bb = beat_cnt;
        write_words(256, 64'd1000, 800, wr);
        check("t2_written", 64'(wr), 64'd256);
        wait_pulses(pb, 2, 2000, "t2_pulses");
        repeat (10) @(posedge clk);
        #1;
        check("t2_beats", 64'(beat_cnt - bb), 64'd256);
        check("t2_txq_empty", 64'(txq.size()), 64'd0);

        // 3: MAC stalled until the buffer fills
        do_reset();
        i_enet_enable = 1'b1; tready_mode = 0;
        pb = pulse_cnt; bb = beat_cnt;
        write_words(300, 64'd2000, 300, wr);
        check("t3_written_full", 64'(wr), 64'd256);
        check("t3_ready_low", o_enet_ready, 1'b0);
        tready_mode = 1;
        write_words(44, 64'd2256, 300, wr);
        check("t3_written_rest", 64'(wr), 64'd44);
        wait_pulses(pb, 2, 1000, "t3_pulses");
        repeat (50) @(posedge clk);
        #1;
        check("t3_beats", 64'(beat_cnt - bb), 64'd256);
        check("t3_pulses_final", 64'(pulse_cnt - pb), 64'd2);
        check("t3_buffered", 64'(txq.size()), 64'd44);

        // 4: RX overflow and drain, plus disabled drop
        do_reset();
        tready_mode = 1;
        i_enet_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_rx_tvalid = 1'b1; i_rx_tdata = 64'(9000 + k);
            @(posedge clk); #1;
        end
        i_rx_tvalid = 1'b0;
        check("rx_disabled_avail", o_enet_data_avail, 1'b0);
        check("rx_disabled_ovf", o_rx_overflow, 1'b0);
        i_enet_enable = 1'b1;
        for (int k = 0; k < 260; k++) begin
            if (k == 256) begin
                check("rx_full_no_ovf", o_rx_overflow, 1'b0);
                check("rx_full_avail", o_enet_data_avail, 1'b1);
            end
            i_rx_tvalid = 1'b1; i_rx_tdata = 64'(k);
            if (rxq.size() < 256) rxq.push_back(64'(k));
            @(posedge clk); #1;
        end
        i_rx_tvalid = 1'b0;
        check("rx_ovf_set", o_rx_overflow, 1'b1);
        i_core_ready = 1'b1;
        c = 0;
        while (rxq.size() != 0 && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        check("rx_drained", 64'(rxq.size()), 64'd0);
        @(posedge clk); #1;
        check("rx_empty_avail", o_enet_data_avail, 1'b0);
        check("rx_ovf_sticky", o_rx_overflow, 1'b1);
        i_core_ready = 1'b0;

        // 5: reset during beat 50
        do_reset();
        i_enet_enable = 1'b1; tready_mode = 1;
        bb = beat_cnt;
        write_words(128, 64'd3000, 200, wr);
        c = 0;
        while (beat_cnt - bb < 50 && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        check("t5_reached_beat50", 64'(beat_cnt - bb >= 50), 64'd1);
        i_rst = 1'b1;
        @(posedge clk); #1;
        check("t5_tvalid_drop", o_tx_tvalid, 1'b0);
        i_rst = 1'b0;
        txq.delete(); exp_len_q.delete(); wcnt = 0; epoch++;
        check("t5_avail", o_enet_data_avail, 1'b0);
        check("t5_ready", o_enet_ready, 1'b1);
        bb = beat_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_beats", 64'(beat_cnt - bb), 64'd0);
        pb = pulse_cnt; bb = beat_cnt;
        write_words(128, 64'd4000, 200, wr);
        wait_pulses(pb, 1, 400, "t5_clean_pulse");
        repeat (10) @(posedge clk);
        #1;
        check("t5_clean_beats", 64'(beat_cnt - bb), 64'd128);
        check("t5_txq_empty", 64'(txq.size()), 64'd0);

        // 6: partial packet on enable drop
        do_reset();
        i_enet_enable = 1'b1; tready_mode = 1;
        pb = pulse_cnt; bb = beat_cnt;
        write_words(40, 64'd5000, 100, wr);
        check("t6_written", 64'(wr), 64'd40);
`ifdef ENET_TX_FLUSH_EN
        exp_len_q.push_back(40);
        wcnt = 0;
`endif
        i_enet_enable = 1'b0;
`ifdef ENET_TX_FLUSH_EN
        wait_pulses(pb, 1, 300, "t6_flush_pulse");
        repeat (20) @(posedge clk);
        #1;
        check("t6_flush_beats", 64'(beat_cnt - bb), 64'd40);
        check("t6_txq_empty", 64'(txq.size()), 64'd0);
`else
        repeat (300) @(posedge clk);
        #1;
        check("t6_no_beats", 64'(beat_cnt - bb), 64'd0);
        check("t6_no_pulse", 64'(pulse_cnt - pb), 64'd0);
        check("t6_buffered", 64'(txq.size()), 64'd40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
